cga_tournament_engine: RTL and testbench

- Self-sequencing compact-GA core. Owns the per-bit probability vector and per-bit cellular-automaton random sources.
- Runs the full loop each generation: samples two candidate individuals, hands them to an external fitness evaluator, takes back the tournament result, and applies the standard cGA update.
- Detects convergence and enforces a generation limit.
- Sits between the testbench/top-level controller and a user fitness unit.

---
 rtl/cga_tournament_engine.sv | 181 ++++++++++++++++++
 tb/tb_cga_tournament_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_tournament_engine.sv
// Compact-GA tournament engine: owns the probability vector and one cellular-
// automaton random source per bit, samples two candidates per generation,
// waits for an external fitness verdict and nudges the vector toward the winner.
module cga_tournament_engine #(
    parameter int WIDTH      = 32,
    parameter int RESOLUTION = 8,
    parameter int TAX_WIDTH  = 4,
    parameter int GEN_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        seed_load,
    input  logic [WIDTH*RESOLUTION-1:0] seed,
    input  logic [TAX_WIDTH-1:0]        step,
    input  logic [GEN_WIDTH-1:0]        max_gen,
    output logic [WIDTH-1:0]            cand_a,
    output logic [WIDTH-1:0]            cand_b,
    output logic                        cand_valid,
    input  logic                        result_valid,
    input  logic                        a_wins,
    output logic [WIDTH-1:0]            best,
    output logic [GEN_WIDTH-1:0]        generation,
    output logic                        busy,
    output logic                        done,
    output logic                        converged
);

    // Wide enough to hold p + step without wrapping, whichever operand is wider.
    localparam int SUM_W = ((RESOLUTION > TAX_WIDTH) ? RESOLUTION : TAX_WIDTH) + 1;
    localparam logic [RESOLUTION-1:0] P_MAX  = '1;
    localparam logic [RESOLUTION-1:0] P_HALF = RESOLUTION'(1) << (RESOLUTION - 1);
    localparam logic [RESOLUTION-1:0] CA_ONE = RESOLUTION'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE_A,
        S_SAMPLE_B,
        S_WAIT,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [RESOLUTION-1:0]   p     [WIDTH];
    logic [RESOLUTION-1:0]   p_upd [WIDTH];
    logic [RESOLUTION-1:0]   ca    [WIDTH];
    logic [WIDTH-1:0]        sample;
    logic [WIDTH-1:0]        winner;
    logic [WIDTH-1:0]        loser;
    logic                    win_a;
    logic                    idle_like;
    logic                    run_start;
    logic                    do_seed;
    logic                    ca_adv;
    logic                    limit_hit;

    // Null-boundary rule 90 (even sources) or rule 150 (odd sources); the
    // shifts feed zeros in at both ends, which is exactly the null boundary.
    function automatic logic [RESOLUTION-1:0] ca_next(input logic [RESOLUTION-1:0] s,
                                                      input logic odd);
        if (odd) return (s << 1) ^ s ^ (s >> 1);
        return (s << 1) ^ (s >> 1);
    endfunction

    function automatic logic [RESOLUTION-1:0] sat_add(input logic [RESOLUTION-1:0] a,
                                                      input logic [TAX_WIDTH-1:0] d);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(d);
        if (sum > SUM_W'(P_MAX)) return P_MAX;
        return sum[RESOLUTION-1:0];
    endfunction

    function automatic logic [RESOLUTION-1:0] sat_sub(input logic [RESOLUTION-1:0] a,
                                                      input logic [TAX_WIDTH-1:0] d);
        if (SUM_W'(d) >= SUM_W'(a)) return '0;
        return a - RESOLUTION'(d);
    endfunction

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign run_start = start && idle_like && !abort;
    assign do_seed   = seed_load && idle_like && !abort;
    assign ca_adv    = !abort && ((state == S_SAMPLE_A) || (state == S_SAMPLE_B));
    assign limit_hit = (max_gen != '0) && (generation == max_gen);

    // Next-state selection; abort overrides every other request.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE,
                S_DONE:     if (start) state_nxt = S_SAMPLE_A;
                S_SAMPLE_A: state_nxt = S_SAMPLE_B;
                S_SAMPLE_B: state_nxt = S_WAIT;
                S_WAIT:     if (result_valid) state_nxt = S_UPDATE;
                S_UPDATE:   state_nxt = S_CHECK;
                S_CHECK:    state_nxt = (converged || limit_hit) ? S_DONE : S_SAMPLE_A;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-bit sampling, consensus, convergence and the candidate update values.
    always_comb begin
        winner    = win_a ? cand_a : cand_b;
        loser     = win_a ? cand_b : cand_a;
        converged = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            sample[i] = ca[i] < p[i];
            best[i]   = p[i][RESOLUTION-1];
            if ((p[i] != '0) && (p[i] != P_MAX)) converged = 1'b0;
            p_upd[i] = p[i];
            if (winner[i] && !loser[i])      p_upd[i] = sat_add(p[i], step);
            else if (!winner[i] && loser[i]) p_upd[i] = sat_sub(p[i], step);
        end
    end

    // Control FSM with registered status outputs and the candidate latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cand_a     <= '0;
            cand_b     <= '0;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_a      <= 1'b0;
            generation <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register in
            // this block sees the pre-edge values, independent of statement order.
            state      <= state_nxt;
            cand_valid <= (state_nxt == S_WAIT);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done       <= (state_nxt == S_DONE);
            if (!abort) begin
                if (run_start)                         generation <= '0;
                if (state == S_SAMPLE_A)               cand_a <= sample;
                if (state == S_SAMPLE_B)               cand_b <= sample;
                if ((state == S_WAIT) && result_valid) win_a  <= a_wins;
                if ((state == S_UPDATE) && (generation != '1))
                    generation <= generation + GEN_WIDTH'(1);
            end
        end
    end

    // Probability vector: restarts at one half, moves only in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: p and ca are flop arrays with defined reset values, not a
            // RAM, so clearing every entry in reset is intended here.
            for (int i = 0; i < WIDTH; i++) p[i] <= P_HALF;
        end else if (run_start) begin
            for (int i = 0; i < WIDTH; i++) p[i] <= P_HALF;
        end else if (!abort && (state == S_UPDATE)) begin
            for (int i = 0; i < WIDTH; i++) p[i] <= p_upd[i];
        end
    end

    // CA random sources: seeded while idle, stepped once per sample cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) ca[i] <= CA_ONE;
        end else if (do_seed) begin
            // An all-zero automaton never leaves zero, so it is replaced by 1.
            for (int i = 0; i < WIDTH; i++)
                ca[i] <= (seed[i*RESOLUTION +: RESOLUTION] == '0) ? CA_ONE
                                                                  : seed[i*RESOLUTION +: RESOLUTION];
        end else if (ca_adv) begin
            for (int i = 0; i < WIDTH; i++) ca[i] <= ca_next(ca[i], (i % 2) == 1);
        end
    end

endmodule

// File: tb/tb_cga_tournament_engine.sv
// Directed bench for cga_tournament_engine at WIDTH=4, RESOLUTION=4.
module tb_cga_tournament_engine;

    localparam int W    = 4;
    localparam int R    = 4;
    localparam int TW   = 4;
    localparam int GW   = 16;
    localparam int PMAX = (1 << R) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic            seed_load;
    logic [W*R-1:0]  seed;
    logic [TW-1:0]   step;
    logic [GW-1:0]   max_gen;
    logic [W-1:0]    cand_a;
    logic [W-1:0]    cand_b;
    logic            cand_valid;
    logic            result_valid;
    logic            a_wins;
    logic [W-1:0]    best;
    logic [GW-1:0]   generation;
    logic            busy;
    logic            done;
    logic            converged;

    cga_tournament_engine #(
        .WIDTH(W), .RESOLUTION(R), .TAX_WIDTH(TW), .GEN_WIDTH(GW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed_load(seed_load), .seed(seed), .step(step), .max_gen(max_gen),
        .cand_a(cand_a), .cand_b(cand_b), .cand_valid(cand_valid),
        .result_valid(result_valid), .a_wins(a_wins), .best(best),
        .generation(generation), .busy(busy), .done(done), .converged(converged)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: probability vector, CA states, expected candidates.
    logic [R-1:0] m_p  [W];
    logic [R-1:0] m_ca [W];
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    function automatic logic [R-1:0] ca_step(input logic [R-1:0] s, input bit odd);
        logic [R-1:0] n;
        logic l, r;
        for (int j = 0; j < R; j++) begin
            l = 1'b0;
            r = 1'b0;
            if (j > 0)     l = s[j-1];
            if (j < R - 1) r = s[j+1];
            n[j] = odd ? (l ^ s[j] ^ r) : (l ^ r);
        end
        return n;
    endfunction

    task automatic model_seed(input logic [W*R-1:0] sd);
        for (int i = 0; i < W; i++)
            m_ca[i] = (sd[i*R +: R] == '0) ? R'(1) : sd[i*R +: R];
    endtask

    task automatic model_start();
        for (int i = 0; i < W; i++) m_p[i] = R'(1 << (R - 1));
    endtask

    task automatic model_sample();
        for (int i = 0; i < W; i++) begin
            m_a[i]  = (m_ca[i] < m_p[i]);
            m_ca[i] = ca_step(m_ca[i], (i % 2) == 1);
        end
        for (int i = 0; i < W; i++) begin
            m_b[i]  = (m_ca[i] < m_p[i]);
            m_ca[i] = ca_step(m_ca[i], (i % 2) == 1);
        end
    endtask

    task automatic model_update(input bit aw, input int stp);
        logic [W-1:0] w, l;
        int v;
        w = aw ? m_a : m_b;
        l = aw ? m_b : m_a;
        for (int i = 0; i < W; i++) begin
            v = int'(m_p[i]);
            if (w[i] && !l[i]) v = (v + stp > PMAX) ? PMAX : v + stp;
            if (!w[i] && l[i]) v = (v - stp < 0) ? 0 : v - stp;
            m_p[i] = R'(v);
        end
    endtask

    task automatic check_p_model(input string tag);
        for (int i = 0; i < W; i++)
            check($sformatf("%s_p%0d", tag, i), 32'(dut.p[i]), 32'(m_p[i]));
    endtask

    task automatic check_p_all(input string tag, input int e3, input int e2, input int e1, input int e0);
        check({tag, "_p3"}, 32'(dut.p[3]), e3);
        check({tag, "_p2"}, 32'(dut.p[2]), e2);
        check({tag, "_p1"}, 32'(dut.p[1]), e1);
        check({tag, "_p0"}, 32'(dut.p[0]), e0);
    endtask

    task automatic wait_cv(input string tag);
        int k = 0;
        while (!cand_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(cand_valid), 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cv"},   32'(cand_valid), 0);
        check({tag, "_gen"},  32'(generation), 0);
        check({tag, "_ca"},   32'(cand_a), 0);
        check({tag, "_cb"},   32'(cand_b), 0);
        check({tag, "_best"}, 32'(best), 'hF);
        check({tag, "_conv"}, 32'(converged), 0);
        check_p_all(tag, 8, 8, 8, 8);
        for (int i = 0; i < W; i++)
            check($sformatf("%s_rng%0d", tag, i), 32'(dut.ca[i]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0; seed = '0;
        step = '0; max_gen = '0; result_valid = 1'b0; a_wins = 1'b0;

        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk) rst_n = 1'b1;

        // Model-checked run: seed 0x1234, result_valid tied high, step 2
        @(negedge clk);
        seed = 16'h1234; seed_load = 1'b1; start = 1'b1; step = 4'd2;
        max_gen = '0; result_valid = 1'b1; a_wins = 1'b1;
        model_seed(seed);
        model_start();
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        check("a_cv_e0", 32'(cand_valid), 0);
        check("a_busy", 32'(busy), 1);
        @(negedge clk);
        check("a_cv_e1", 32'(cand_valid), 0);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("a%0d_cv", g), 32'(cand_valid), 1);
            model_sample();
            check($sformatf("a%0d_ca", g), 32'(cand_a), 32'(m_a));
            check($sformatf("a%0d_cb", g), 32'(cand_b), 32'(m_b));
            model_update(1'b1, 2);
            @(negedge clk);
            check($sformatf("a%0d_cv_drop", g), 32'(cand_valid), 0);
            check($sformatf("a%0d_gen_pre", g), 32'(generation), g);
            @(negedge clk);
            check($sformatf("a%0d_gen", g), 32'(generation), g + 1);
            check_p_model($sformatf("a%0d", g));
            repeat (3) @(negedge clk);
        end
        // Abort in WAIT, with a result present in the same cycle
        check("a3_cv", 32'(cand_valid), 1);
        model_sample();
        check("a3_ca", 32'(cand_a), 32'(m_a));
        check("a3_cb", 32'(cand_b), 32'(m_b));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; result_valid = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_cv", 32'(cand_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_gen", 32'(generation), 3);
        check_p_model("abort");

        // Directed convergence run: seed 0x481C, step 15
        @(negedge clk);
        seed = 16'h481C; seed_load = 1'b1; start = 1'b1; step = 4'd15; a_wins = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        wait_cv("b0_cv");
        check("b0_ca", 32'(cand_a), 'b1010);
        check("b0_cb", 32'(cand_b), 'b0110);
        repeat (20) @(negedge clk);
        check("hold_ca", 32'(cand_a), 'b1010);
        check("hold_cb", 32'(cand_b), 'b0110);
        check("hold_cv", 32'(cand_valid), 1);
        check("hold_gen", 32'(generation), 0);
        check_p_all("hold", 8, 8, 8, 8);
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        @(negedge clk);
        check_p_all("b0", 15, 0, 8, 8);
        check("b0_best", 32'(best), 'b1011);
        check("b0_conv", 32'(converged), 0);
        check("b0_gen", 32'(generation), 1);
        @(negedge clk);
        @(negedge clk);
        result_valid = 1'b1; a_wins = 1'b0;
        @(negedge clk);
        result_valid = 1'b0; a_wins = 1'b1;
        check("b1_cv", 32'(cand_valid), 1);
        repeat (3) @(negedge clk);
        check("ign_cv", 32'(cand_valid), 1);
        check("ign_gen", 32'(generation), 1);
        check_p_all("ign", 15, 0, 8, 8);
        check("b1_ca", 32'(cand_a), 'b1010);
        check("b1_cb", 32'(cand_b), 'b1001);
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        wait_done("b_done");
        check("b_conv", 32'(converged), 1);
        check("b_best", 32'(best), 'b1010);
        check("b_gen", 32'(generation), 2);
        check("b_busy", 32'(busy), 0);
        check_p_all("b_fin", 15, 0, 15, 0);

        // Generation limit: max_gen 3, step 1, restart from DONE
        @(negedge clk);
        seed = 16'h1234; seed_load = 1'b1; start = 1'b1; step = 4'd1;
        max_gen = 16'd3; result_valid = 1'b1; a_wins = 1'b1;
        model_seed(seed);
        model_start();
        for (int g = 0; g < 3; g++) begin
            model_sample();
            model_update(1'b1, 1);
        end
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        check("c_done_clr", 32'(done), 0);
        check("c_busy", 32'(busy), 1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("c_done_edges", n, 15);
        check("c_done", 32'(done), 1);
        check("c_gen", 32'(generation), 3);
        check("c_conv", 32'(converged), 0);
        check("c_busy_end", 32'(busy), 0);
        check_p_model("c");
        result_valid = 1'b0;

        // Asynchronous reset in SAMPLE_B with a result pending
        @(negedge clk);
        start = 1'b1; max_gen = '0; step = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        result_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        check("arst_idle_busy", 32'(busy), 0);
        check("arst_idle_cv", 32'(cand_valid), 0);

        // First run after reset uses the reset CA value of 1 in every source
        for (int i = 0; i < W; i++) m_ca[i] = R'(1);
        model_start();
        model_sample();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cv("e_cv");
        check("e_ca", 32'(cand_a), 32'(m_a));
        check("e_cb", 32'(cand_b), 32'(m_b));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
